// File: rtl/common.sv
// Shared scalar types used across the pipeline front end.
package common;

    typedef logic [63:0] word_t;
    typedef logic        u1;

endpackage

// File: rtl/fetch_pkg.sv
// Types and constants for the instruction-fetch stage and its queue.
package fetch_pkg;

    import common::*;

    typedef struct packed {
        word_t       pc;
        logic [31:0] raw_instr;
    } fetch_data_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        IDLE = 2'd3
    } fetch_state_t;

    localparam word_t RESET_PC = 64'h8000_0000;

    function automatic word_t next_pc(input word_t pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched instructions between the memory response and decode.
// Flush beats push and pop; the head entry is presented without a read delay.
module fetch_queue
    import common::*;
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  u1                        push,
    input  fetch_data_t              push_data,
    input  u1                        pop,
    input  u1                        flush,
    output fetch_data_t              head,
    output u1                        full,
    output u1                        empty,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int AW = $clog2(QDEPTH);

    fetch_data_t      mem [QDEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(QDEPTH));

    assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop && !flush));
    assert property (@(posedge clk) disable iff (!reset) !(pop && empty && !flush));

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: one outstanding word request, queued responses, redirects.
// Define FETCH_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module fetch
    import common::*;
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC = fetch_pkg::RESET_PC,
    parameter int    QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic         ireq_valid,
    output logic [63:0]  ireq_addr,
    input  logic         ireq_ready,
    input  logic         iresp_valid,
    input  logic [31:0]  iresp_data,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic         out_valid,
    output fetch_data_t  out_data,
    input  logic         out_ready
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t  state_reg, state_next;
    word_t         fetch_pc_reg, fetch_pc_next;
    word_t         req_pc_reg, req_pc_next;
    u1             stale_reg, stale_next;

    fetch_data_t   q_head;
    fetch_data_t   resp_data;
    u1             q_full, q_empty, q_push, q_pop;
    logic [CW-1:0] q_count;
    logic [CW-1:0] count_after;
    u1             req_fire, resp_take, space_after;

    // A request stays on the bus with its original address after a redirect;
    // stale_reg marks that it will be dropped once accepted.
    assign ireq_valid = reset && (state_reg == REQ);
    assign ireq_addr  = stale_reg ? req_pc_reg : fetch_pc_reg;
    assign req_fire   = ireq_valid && ireq_ready;
    assign resp_take  = (state_reg == WAIT) && iresp_valid && !redirect_valid;
    assign resp_data  = '{pc: req_pc_reg, raw_instr: iresp_data};
    assign q_pop      = !q_empty && out_ready;

`ifdef FETCH_BYPASS_EN
    u1 bypass;
    assign bypass    = resp_take && q_empty;
    assign out_valid = !q_empty || bypass;
    assign out_data  = !q_empty ? q_head : (bypass ? resp_data : '0);
    assign q_push    = resp_take && !(bypass && out_ready) && (!q_full || q_pop);
`else
    assign out_valid = !q_empty;
    assign out_data  = q_empty ? '0 : q_head;
    assign q_push    = resp_take && (!q_full || q_pop);
`endif

    assign count_after = q_count + CW'(q_push) - CW'(q_pop);
    assign space_after = count_after < CW'(QDEPTH);

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;
        stale_next    = stale_reg;
        case (state_reg)
            REQ: begin
                if (req_fire) begin
                    state_next  = (redirect_valid || stale_reg) ? DROP : WAIT;
                    req_pc_next = ireq_addr;
                    stale_next  = 1'b0;
                    if (!stale_reg) begin
                        fetch_pc_next = next_pc(fetch_pc_reg);
                    end
                end else if (redirect_valid) begin
                    stale_next  = 1'b1;
                    req_pc_next = ireq_addr;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_next = iresp_valid ? REQ : DROP;
                end else if (iresp_valid) begin
                    state_next = space_after ? REQ : IDLE;
                end
            end
            DROP: begin
                if (iresp_valid) begin
                    state_next = REQ;
                end
            end
            IDLE: begin
                if (redirect_valid || space_after) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
        // Redirect wins over any sequential PC update.
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & ~64'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= REQ;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            stale_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
            stale_reg    <= stale_next;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (resp_data),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

endmodule
